// File: rtl/rr_arb_dff_stage.sv
// -----------------------------------------------------------------------------
// rr_arb_dff_stage
//
// Round-robin arbiter feeding a single registered output stage. Up to NUM_REQ
// requesters offer beats; one is granted per cycle whenever the output
// register can take a beat. The winning payload and its requester index are
// captured one cycle later.
//
// Handshake: a beat moves across an interface on a clock edge when its valid
// and ready are both high at that edge. Upstream, iRdy[k] is high only for the
// granted requester and only when the output register can load
// (load = ~oVld | oRdy). Downstream, the held beat leaves on oVld & oRdy.
// A valid beat is never dropped or changed while it is stalled.
//
// Parameters
//   NUM_REQ  : number of requesters (2..16)
//   WIDTH    : payload width
//   INI_DATA : reset value of oDat
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst_n    : synchronous active-low reset
//   iVld     : per-requester valid
//   iDat     : per-requester payload, packed [NUM_REQ-1:0][WIDTH-1:0]
//   iRdy     : per-requester accept (one-hot or zero)
//   oVld     : output register holds a valid beat
//   oDat     : payload of the held beat
//   oIdx     : requester index of the held beat
//   oRdy     : downstream accept
//   dbg_ptr  : current round-robin pointer (observation only)
// -----------------------------------------------------------------------------
module rr_arb_dff_stage #(
   parameter int                NUM_REQ  = 4,
   parameter int                WIDTH    = 8,
   parameter logic [WIDTH-1:0]  INI_DATA = '0,
   localparam int               IDX_W    = $clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              iVld,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]   iDat,
   output logic [NUM_REQ-1:0]              iRdy,
   output logic                            oVld,
   output logic [WIDTH-1:0]                oDat,
   output logic [IDX_W-1:0]                oIdx,
   input  logic                            oRdy,
   output logic [IDX_W-1:0]                dbg_ptr
);

   // Elaboration-time parameter sanity check.
   if (NUM_REQ < 2 || WIDTH < 1) begin : g_param_check
`ifdef CHECK_ERR_EXIT
      $fatal(1, "rr_arb_dff_stage: illegal parameters NUM_REQ=%0d WIDTH=%0d", NUM_REQ, WIDTH);
`else
      $error("rr_arb_dff_stage: illegal parameters NUM_REQ=%0d WIDTH=%0d", NUM_REQ, WIDTH);
`endif
   end

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   logic              ovld_q, ovld_d;
   logic [WIDTH-1:0]  odat_q, odat_d;
   logic [IDX_W-1:0]  oidx_q, oidx_d;
   logic [IDX_W-1:0]  ptr_q,  ptr_d;

   logic              load;
   logic              gnt_found;
   logic [IDX_W-1:0]  gnt_idx;
   logic [IDX_W-1:0]  cand_idx;

   // The register can take a new beat when empty or when its beat leaves now.
   assign load = ~ovld_q | oRdy;

   // Rotating priority search: ptr has highest priority, then ptr+1, ...,
   // wrapping modulo NUM_REQ. The first valid candidate wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand_idx  = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         cand_idx = IDX_W'((int'(ptr_q) + j) % NUM_REQ);
         if (!gnt_found && iVld[cand_idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand_idx;
         end
      end
   end

   // Accept only outside reset, so nothing is consumed from upstream while the
   // stage is being cleared.
   always_comb begin
      iRdy = '0;
      if (rst_n && load && gnt_found) begin
         iRdy[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      ovld_d = ovld_q;
      odat_d = odat_q;
      oidx_d = oidx_q;
      ptr_d  = ptr_q;
      if (load) begin
         if (gnt_found) begin
            ovld_d = 1'b1;
            odat_d = iDat[gnt_idx];
            oidx_d = gnt_idx;
            // Winner drops to lowest priority; the pointer never leaves 0..NUM_REQ-1.
            ptr_d  = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
         end else begin
            // Drain: payload, index and pointer keep their last values.
            ovld_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovld_q <= 1'b0;
         odat_q <= INI_DATA;
         oidx_q <= '0;
         ptr_q  <= '0;
      end else begin
         ovld_q <= ovld_d;
         odat_q <= odat_d;
         oidx_q <= oidx_d;
         ptr_q  <= ptr_d;
      end
   end

   assign oVld    = ovld_q;
   assign oDat    = odat_q;
   assign oIdx    = oidx_q;
   assign dbg_ptr = ptr_q;

endmodule

// File: tb/tb_rr_arb_dff_stage.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_dff_stage
//
// Bench for rr_arb_dff_stage with NUM_REQ=4, WIDTH=8, INI_DATA=8'hA5.
// Phase 1 walks a table of hand-computed vectors (reset, rotation, skip/wrap,
// backpressure, idle drain, reset mid-stall). Phase 2 drives random traffic
// against a small behavioural model with an expected-beat queue.
// Inputs change 1 time unit after the rising edge; iRdy is checked at the
// falling edge and registered outputs 1 time unit after the next rising edge.
// -----------------------------------------------------------------------------
module tb_rr_arb_dff_stage;

   localparam int              NUM_REQ  = 4;
   localparam int              WIDTH    = 8;
   localparam int              IDX_W    = 2;
   localparam logic [WIDTH-1:0] INI_DATA = 8'hA5;

   // ---------------- clock / reset ----------------
   logic                          clk = 1'b1;
   logic                          rst_n;
   logic [NUM_REQ-1:0]            iVld;
   logic [NUM_REQ-1:0][WIDTH-1:0] iDat;
   logic [NUM_REQ-1:0]            iRdy;
   logic                          oVld;
   logic [WIDTH-1:0]              oDat;
   logic [IDX_W-1:0]              oIdx;
   logic                          oRdy;
   logic [IDX_W-1:0]              dbg_ptr;

   always #5 clk = ~clk;

   rr_arb_dff_stage #(
      .NUM_REQ  (NUM_REQ),
      .WIDTH    (WIDTH),
      .INI_DATA (INI_DATA)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .iVld    (iVld),
      .iDat    (iDat),
      .iRdy    (iRdy),
      .oVld    (oVld),
      .oDat    (oDat),
      .oIdx    (oIdx),
      .oRdy    (oRdy),
      .dbg_ptr (dbg_ptr)
   );

   // ---------------- scoreboard state ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [IDX_W+WIDTH-1:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic               rst_n;
      logic [NUM_REQ-1:0] ivld;
      logic [WIDTH-1:0]   base;      // iDat[k] = base + k
      logic               ordy;
      logic [NUM_REQ-1:0] exp_irdy;  // during the cycle
      logic               exp_ovld;  // after the edge
      logic [WIDTH-1:0]   exp_odat;
      logic [IDX_W-1:0]   exp_oidx;
      logic [IDX_W-1:0]   exp_ptr;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [7:0] b,
                               input logic o, input logic [3:0] ir, input logic ov,
                               input logic [7:0] od, input logic [1:0] oi, input logic [1:0] p);
      vec_t t;
      t.rst_n = r; t.ivld = v; t.base = b; t.ordy = o; t.exp_irdy = ir;
      t.exp_ovld = ov; t.exp_odat = od; t.exp_oidx = oi; t.exp_ptr = p;
      return t;
   endfunction

   task automatic drive(input logic r, input logic [NUM_REQ-1:0] v,
                        input logic [NUM_REQ-1:0][WIDTH-1:0] d, input logic o);
      rst_n = r;
      iVld  = v;
      iDat  = d;
      oRdy  = o;
   endtask

   // ---------------- reference model (random phase) ----------------
   logic              m_vld;
   logic [WIDTH-1:0]  m_dat;
   logic [IDX_W-1:0]  m_idx;
   logic [IDX_W-1:0]  m_ptr;

   initial begin
      logic [NUM_REQ-1:0][WIDTH-1:0] d;
      logic [NUM_REQ-1:0]            e_irdy;
      logic [IDX_W+WIDTH-1:0]        beat;
      logic                          granted;
      int                            g;

      //            rst  ivld     base   ordy irdy     ovld odat   oidx ptr
      vecs[0]  = mk(0, 4'b1111, 8'h10, 1, 4'b0000, 0, 8'hA5, 0, 0); // reset
      vecs[1]  = mk(0, 4'b1111, 8'h10, 1, 4'b0000, 0, 8'hA5, 0, 0);
      vecs[2]  = mk(1, 4'b1111, 8'h10, 1, 4'b0001, 1, 8'h10, 0, 1); // rotation
      vecs[3]  = mk(1, 4'b1111, 8'h10, 1, 4'b0010, 1, 8'h11, 1, 2);
      vecs[4]  = mk(1, 4'b1111, 8'h10, 1, 4'b0100, 1, 8'h12, 2, 3);
      vecs[5]  = mk(1, 4'b1111, 8'h10, 1, 4'b1000, 1, 8'h13, 3, 0);
      vecs[6]  = mk(1, 4'b1111, 8'h10, 1, 4'b0001, 1, 8'h10, 0, 1);
      vecs[7]  = mk(1, 4'b1111, 8'h10, 1, 4'b0010, 1, 8'h11, 1, 2);
      vecs[8]  = mk(1, 4'b1111, 8'h10, 1, 4'b0100, 1, 8'h12, 2, 3);
      vecs[9]  = mk(1, 4'b1111, 8'h10, 1, 4'b1000, 1, 8'h13, 3, 0);
      vecs[10] = mk(1, 4'b0100, 8'h10, 1, 4'b0100, 1, 8'h12, 2, 3); // bring ptr to 3
      vecs[11] = mk(1, 4'b0101, 8'h30, 1, 4'b0001, 1, 8'h30, 0, 1); // skip + wrap
      vecs[12] = mk(1, 4'b0101, 8'h30, 1, 4'b0100, 1, 8'h32, 2, 3);
      vecs[13] = mk(1, 4'b0001, 8'h22, 1, 4'b0001, 1, 8'h22, 0, 1); // load 8'h22
      vecs[14] = mk(1, 4'b0010, 8'h40, 0, 4'b0000, 1, 8'h22, 0, 1); // stall x3
      vecs[15] = mk(1, 4'b0010, 8'h40, 0, 4'b0000, 1, 8'h22, 0, 1);
      vecs[16] = mk(1, 4'b0010, 8'h40, 0, 4'b0000, 1, 8'h22, 0, 1);
      vecs[17] = mk(1, 4'b0010, 8'h40, 1, 4'b0010, 1, 8'h41, 1, 2); // release
      vecs[18] = mk(1, 4'b0000, 8'h40, 1, 4'b0000, 0, 8'h41, 1, 2); // idle drain
      vecs[19] = mk(1, 4'b0000, 8'h40, 1, 4'b0000, 0, 8'h41, 1, 2);
      vecs[20] = mk(1, 4'b0100, 8'h50, 0, 4'b0100, 1, 8'h52, 2, 3); // load then stall
      vecs[21] = mk(1, 4'b0100, 8'h50, 0, 4'b0000, 1, 8'h52, 2, 3);
      vecs[22] = mk(0, 4'b1111, 8'h50, 0, 4'b0000, 0, 8'hA5, 0, 0); // reset mid-stall
      vecs[23] = mk(1, 4'b1010, 8'h60, 1, 4'b0010, 1, 8'h61, 1, 2); // lowest valid from 0
      vecs[24] = mk(1, 4'b1010, 8'h60, 1, 4'b1000, 1, 8'h63, 3, 0); // wrap to 0

      // ---- phase 1: table ----
      for (int i = 0; i < NV; i++) begin
         for (int k = 0; k < NUM_REQ; k++) d[k] = vecs[i].base + WIDTH'(k);
         drive(vecs[i].rst_n, vecs[i].ivld, d, vecs[i].ordy);
         @(negedge clk);
         chk($sformatf("v%0d_irdy", i), 32'(iRdy), 32'(vecs[i].exp_irdy));
         @(posedge clk); #1;
         chk($sformatf("v%0d_ovld", i), 32'(oVld),    32'(vecs[i].exp_ovld));
         chk($sformatf("v%0d_odat", i), 32'(oDat),    32'(vecs[i].exp_odat));
         chk($sformatf("v%0d_oidx", i), 32'(oIdx),    32'(vecs[i].exp_oidx));
         chk($sformatf("v%0d_ptr",  i), 32'(dbg_ptr), 32'(vecs[i].exp_ptr));
      end

      // ---- phase 2: random traffic vs model ----
      m_vld = 1'b1; m_dat = 8'h63; m_idx = 2'd3; m_ptr = 2'd0;
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < NUM_REQ; k++) d[k] = WIDTH'($urandom_range(0, 255));
         drive(($urandom_range(0, 29) != 0), NUM_REQ'($urandom_range(0, 15)), d,
               ($urandom_range(0, 3) != 0));

         e_irdy  = '0;
         granted = 1'b0;
         if (rst_n && (!m_vld || oRdy)) begin
            for (int j = 0; j < NUM_REQ; j++) begin
               g = (int'(m_ptr) + j) % NUM_REQ;
               if (!granted && iVld[g]) begin
                  granted   = 1'b1;
                  e_irdy[g] = 1'b1;
                  exp_q.push_back({IDX_W'(g), iDat[g]});
                  m_ptr = IDX_W'((g + 1) % NUM_REQ);
               end
            end
         end
         if (!rst_n) begin
            m_vld = 1'b0; m_dat = INI_DATA; m_idx = '0; m_ptr = '0;
         end else if (!m_vld || oRdy) begin
            m_vld = granted;
         end

         @(negedge clk);
         chk("rnd_irdy", 32'(iRdy), 32'(e_irdy));
         @(posedge clk); #1;
         if (granted) begin
            if (exp_q.size() == 0) begin
               chk("rnd_queue_empty", 32'd0, 32'd1);
            end else begin
               beat  = exp_q.pop_front();
               m_idx = beat[IDX_W+WIDTH-1:WIDTH];
               m_dat = beat[WIDTH-1:0];
               chk("rnd_beat_oidx", 32'(oIdx), 32'(m_idx));
               chk("rnd_beat_odat", 32'(oDat), 32'(m_dat));
            end
         end
         chk("rnd_ovld", 32'(oVld),    32'(m_vld));
         chk("rnd_hold_odat", 32'(oDat), 32'(m_dat));
         chk("rnd_hold_oidx", 32'(oIdx), 32'(m_idx));
         chk("rnd_ptr",  32'(dbg_ptr), 32'(m_ptr));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
